// File: rtl/inst_serializer.sv
// inst_serializer: turns one 4-slot fetch packet into single instructions for scalar decode
module inst_serializer #(
    parameter int FETCH_WIDTH    = 4,
    parameter int INST_WIDTH     = 32,
    parameter int PC_STEP        = 4,
    parameter int TRUNC_ON_TAKEN = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_in_valid,
    output logic                  io_in_ready,
    input  logic [INST_WIDTH-1:0] io_in_bits_inst_0_inst,
    input  logic                  io_in_bits_inst_0_valid,
    input  logic                  io_in_bits_inst_0_predictBrTaken,
    input  logic [INST_WIDTH-1:0] io_in_bits_inst_1_inst,
    input  logic                  io_in_bits_inst_1_valid,
    input  logic                  io_in_bits_inst_1_predictBrTaken,
    input  logic [INST_WIDTH-1:0] io_in_bits_inst_2_inst,
    input  logic                  io_in_bits_inst_2_valid,
    input  logic                  io_in_bits_inst_2_predictBrTaken,
    input  logic [INST_WIDTH-1:0] io_in_bits_inst_3_inst,
    input  logic                  io_in_bits_inst_3_valid,
    input  logic                  io_in_bits_inst_3_predictBrTaken,
    input  logic [INST_WIDTH-1:0] io_in_bits_pc,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [INST_WIDTH-1:0] io_out_bits_inst,
    output logic [INST_WIDTH-1:0] io_out_bits_pc,
    output logic                  io_out_bits_predictBrTaken,
    output logic                  io_out_bits_last,
    output logic                  io_busy,
    input  logic                  io_flush
);
    logic [INST_WIDTH-1:0]  r_inst [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] r_taken;
    logic [FETCH_WIDTH-1:0] r_pending;
    logic [INST_WIDTH-1:0]  r_pc;
    logic [INST_WIDTH-1:0]  w_in_inst [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] w_in_vld;
    logic [FETCH_WIDTH-1:0] w_in_tk;
    logic [FETCH_WIDTH-1:0] w_hit;
    logic [FETCH_WIDTH-1:0] w_hit_low;
    logic [FETCH_WIDTH-1:0] w_prefix;
    logic [FETCH_WIDTH-1:0] w_in_mask;
    logic [FETCH_WIDTH-1:0] w_cur_oh;
    logic [1:0]             w_cur;
    logic                   w_busy;
    logic                   w_last;
    logic                   w_out_fire;
    logic                   w_in_fire;

    assign w_in_inst = '{io_in_bits_inst_0_inst, io_in_bits_inst_1_inst,
                         io_in_bits_inst_2_inst, io_in_bits_inst_3_inst};
    assign w_in_vld  = {io_in_bits_inst_3_valid, io_in_bits_inst_2_valid,
                        io_in_bits_inst_1_valid, io_in_bits_inst_0_valid};
    assign w_in_tk   = {io_in_bits_inst_3_predictBrTaken, io_in_bits_inst_2_predictBrTaken,
                        io_in_bits_inst_1_predictBrTaken, io_in_bits_inst_0_predictBrTaken};

    // The first valid taken slot ends the packet: keep slots 0..t only.
    assign w_hit     = w_in_vld & w_in_tk;
    assign w_hit_low = w_hit & (-w_hit);
    assign w_prefix  = (TRUNC_ON_TAKEN != 0 && w_hit != '0) ?
                       (w_hit_low | (w_hit_low - FETCH_WIDTH'(1))) : '1;
    assign w_in_mask = w_in_vld & w_prefix;

    // Lowest pending slot is the one presented to decode.
    assign w_cur_oh = r_pending & (-r_pending);
    assign w_cur    = {w_cur_oh[3] | w_cur_oh[2], w_cur_oh[3] | w_cur_oh[1]};
    assign w_busy   = |r_pending;
    assign w_last   = w_busy && ((r_pending & (r_pending - FETCH_WIDTH'(1))) == '0);

    assign io_out_valid = w_busy & ~io_flush;
    assign w_out_fire   = io_out_valid & io_out_ready;
    // Accepting while the last slot leaves gives back-to-back packets without a bubble.
    assign io_in_ready  = ~io_flush & (~w_busy | (w_out_fire & w_last));
    assign w_in_fire    = io_in_valid & io_in_ready;

    assign io_out_bits_inst           = r_inst[w_cur];
    assign io_out_bits_pc             = r_pc + INST_WIDTH'(PC_STEP) * INST_WIDTH'(w_cur);
    assign io_out_bits_predictBrTaken = r_taken[w_cur];
    assign io_out_bits_last           = w_last;
    assign io_busy                    = w_busy;

    // Packet capture, per-slot advance and flush of the pending mask.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_taken   <= '0;
            r_pc      <= '0;
            for (int k = 0; k < FETCH_WIDTH; k++) r_inst[k] <= '0;
        end else if (io_flush) begin
            r_pending <= '0;
        end else if (w_in_fire) begin
            r_pending <= w_in_mask;
            r_taken   <= w_in_tk;
            r_pc      <= io_in_bits_pc;
            for (int k = 0; k < FETCH_WIDTH; k++) r_inst[k] <= w_in_inst[k];
        end else if (w_out_fire) begin
            r_pending <= r_pending & ~w_cur_oh;
        end
    end
endmodule

// File: tb/tb_inst_serializer.sv
// tb_inst_serializer: directed test-plan scenarios plus random traffic against a queue-based model
module tb_inst_serializer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_in_valid = 1'b0;
    logic        io_out_ready = 1'b0;
    logic        io_flush = 1'b0;
    logic [31:0] in_inst [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [3:0]  in_v = 4'h0;
    logic [3:0]  in_t = 4'h0;
    logic [31:0] in_pc = 32'h0;
    logic        io_in_ready;
    logic        io_out_valid;
    logic [31:0] io_out_bits_inst;
    logic [31:0] io_out_bits_pc;
    logic        io_out_bits_predictBrTaken;
    logic        io_out_bits_last;
    logic        io_busy;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        tk;
    } item_t;

    item_t q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    bit    accepted;

    inst_serializer dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_bits_inst_0_inst(in_inst[0]), .io_in_bits_inst_0_valid(in_v[0]), .io_in_bits_inst_0_predictBrTaken(in_t[0]),
        .io_in_bits_inst_1_inst(in_inst[1]), .io_in_bits_inst_1_valid(in_v[1]), .io_in_bits_inst_1_predictBrTaken(in_t[1]),
        .io_in_bits_inst_2_inst(in_inst[2]), .io_in_bits_inst_2_valid(in_v[2]), .io_in_bits_inst_2_predictBrTaken(in_t[2]),
        .io_in_bits_inst_3_inst(in_inst[3]), .io_in_bits_inst_3_valid(in_v[3]), .io_in_bits_inst_3_predictBrTaken(in_t[3]),
        .io_in_bits_pc(in_pc),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_bits_inst(io_out_bits_inst), .io_out_bits_pc(io_out_bits_pc),
        .io_out_bits_predictBrTaken(io_out_bits_predictBrTaken), .io_out_bits_last(io_out_bits_last),
        .io_busy(io_busy), .io_flush(io_flush)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: list the instructions the packet should yield, in order.
    task automatic expand();
        q.delete();
        for (int k = 0; k < 4; k++) begin
            if (in_v[k]) begin
                q.push_back('{in_inst[k], in_pc + 32'(4 * k), in_t[k]});
                if (in_t[k]) break;
            end
        end
    endtask

    task automatic tick();
        bit ev;
        bit er;
        @(negedge clock);
        ev = q.size() > 0 && !io_flush;
        er = !io_flush && (q.size() == 0 || (io_out_ready && q.size() == 1));
        check("out_valid", 32'(io_out_valid), 32'(ev));
        check("busy", 32'(io_busy), 32'(q.size() > 0));
        check("in_ready", 32'(io_in_ready), 32'(er));
        if (ev) begin
            check("inst", io_out_bits_inst, q[0].inst);
            check("pc", io_out_bits_pc, q[0].pc);
            check("taken", 32'(io_out_bits_predictBrTaken), 32'(q[0].tk));
            check("last", 32'(io_out_bits_last), 32'(q.size() == 1));
        end
        accepted = 1'b0;
        if (io_flush) q.delete();
        else if (io_in_valid && er) begin
            expand();
            accepted = 1'b1;
        end else if (ev && io_out_ready) void'(q.pop_front());
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [3:0] v, input logic [3:0] t);
        in_pc = pc;
        in_v = v;
        in_t = t;
        for (int k = 0; k < 4; k++) in_inst[k] = $urandom;
        io_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (accepted) break;
        end
        check("accept", 32'(accepted), 32'd1);
        io_in_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_out_valid", 32'(io_out_valid), 32'd0);
        check("rst_busy", 32'(io_busy), 32'd0);
        check("rst_in_ready", 32'(io_in_ready), 32'd1);
        check("rst_inst", io_out_bits_inst, 32'd0);
        check("rst_pc", io_out_bits_pc, 32'd0);
        check("rst_taken", 32'(io_out_bits_predictBrTaken), 32'd0);
        check("rst_last", 32'(io_out_bits_last), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        io_out_ready = 1'b1;
        offer(32'h8000_0000, 4'b1111, 4'b0000);
        repeat (5) tick();
        offer(32'h0000_0100, 4'b0111, 4'b0010);
        repeat (3) tick();
        offer(32'h0000_0200, 4'b0011, 4'b0000);
        offer(32'h0000_0300, 4'b0011, 4'b0000);
        repeat (3) tick();
        offer(32'h0000_0500, 4'b1111, 4'b0000);
        io_out_ready = 1'b0;
        repeat (3) tick();
        io_out_ready = 1'b1;
        repeat (5) tick();
        offer(32'h0000_0600, 4'b1111, 4'b0000);
        tick();
        io_flush = 1'b1;
        tick();
        io_flush = 1'b0;
        tick();
        offer(32'h0000_0400, 4'b1111, 4'b0000);
        repeat (5) tick();
        offer(32'h0000_0700, 4'b0000, 4'b1111);
        repeat (2) tick();
        offer(32'hFFFF_FFFC, 4'b0011, 4'b0000);
        repeat (3) tick();
        offer(32'h0000_0800, 4'b1101, 4'b0000);
        repeat (4) tick();
        offer(32'h0000_0900, 4'b1111, 4'b0000);
        tick();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(io_out_valid), 32'd0);
        check("midrst_busy", 32'(io_busy), 32'd0);
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        repeat (400) begin
            io_in_valid = 1'($urandom_range(0, 1));
            in_v = 4'($urandom);
            in_t = 4'($urandom & $urandom);
            in_pc = {$urandom} & 32'hFFFF_FFFC;
            for (int k = 0; k < 4; k++) in_inst[k] = $urandom;
            io_out_ready = ($urandom_range(0, 3) != 0);
            io_flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
